cmplx_add_sched: RTL and testbench
==================================

Name: cmplx_add_sched

Overview:
Scheduler that time-shares one external W-bit CLA adder (cla64 at W=64) to form the final complex product terms from four partial products supplied by the vedic multiplier array: re = ac - bd, im = ad + bc. It sits between the partial-product stage and the output register stage of the complex multiplier. It accepts operands through a valid/ready handshake and drives the adder for two passes. Results are held until the consumer accepts them.

Parameters:
W, 64, operand, adder and result width in bits; two's-complement signed.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands
ac  input  W  partial product a*c
bd  input  W  partial product b*d
ad  input  W  partial product a*d
bc  input  W  partial product b*c
add_a  output  W  shared adder operand a
add_b  output  W  shared adder operand b
add_cin  output  1  shared adder carry-in
add_sum  input  W  shared adder sum (combinational return)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
re  output  W  real part, ac - bd, mod 2^W
im  output  W  imaginary part, ad + bc, mod 2^W
re_ovf  output  1  signed overflow on re
im_ovf  output  1  signed overflow on im
busy  output  1  state is not IDLE

Behaviour:
- Reset (asynchronous, active-high) sets the following. State = IDLE. Operand registers = 0. re = im = 0. re_ovf = im_ovf = 0. out_valid = 0. in_ready is forced to 0 while rst is high.
- States: IDLE, REAL, IMAG, DONE. Encoding is free.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Operands are accepted on a rising edge with in_valid & in_ready. ac/bd/ad/bc are latched internally, and the next state is REAL.
- REAL: add_a = ac_q, add_b = ~bd_q, add_cin = 1. On the edge, re <= add_sum and re_ovf <= (ac_q[W-1] != bd_q[W-1]) & (add_sum[W-1] != ac_q[W-1]). Next state is IMAG unconditionally.
- IMAG: add_a = ad_q, add_b = bc_q, add_cin = 0. On the edge, im <= add_sum and im_ovf <= (ad_q[W-1] == bc_q[W-1]) & (add_sum[W-1] != ad_q[W-1]). Next state is DONE.
- DONE: out_valid = 1. re, im and both flags are stable.
  - out_ready = 0: stay in DONE and hold all outputs.
  - out_ready = 1 and in_valid = 0: go to IDLE.
  - out_ready = 1 and in_valid = 1: accept the new operands and go to REAL directly.
- In IDLE and DONE: add_a = 0, add_b = 0, add_cin = 0.
- re/im/flags keep their last values after leaving DONE until overwritten by the next REAL/IMAG pass.
- Latency: out_valid rises 3 cycles after the accepting edge. Sustained throughput is one result per 3 cycles with out_ready tied high.
- in_valid in REAL/IMAG is ignored (in_ready = 0). Operand inputs may change freely outside the accepting edge.
- busy = (state != IDLE).
- Adder is combinational: add_sum is sampled in the same cycle its operands are driven. No multicycle path is assumed.
- Reset mid-operation (any state) aborts the operation immediately. No partial result is ever presented with out_valid = 1.
- Arithmetic is modulo 2^W. Overflow flags are the only indication of wrap.

Test Plan:
- Reset: assert rst mid-cycle with in_valid = 1 -> in_ready = 0, out_valid = 0, re = im = 0, busy = 0. After release, in_ready = 1 and the flags are 0.
- Basic (W=64): ac=10, bd=3, ad=4, bc=5 accepted at edge 0 -> adder sees add_cin = 1 in cycle 1 and 0 in cycle 2. out_valid = 1 from cycle 3 with re = 7, im = 9, both flags 0.
- Negative/overflow: ac=0, bd=1, ad=bc=0x7FFF_FFFF_FFFF_FFFF -> re = 0xFFFF_FFFF_FFFF_FFFF, re_ovf = 0, im = 0xFFFF_FFFF_FFFF_FFFE, im_ovf = 1. Then ac=0x8000_0000_0000_0000, bd=1 -> re = 0x7FFF_FFFF_FFFF_FFFF, re_ovf = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE -> re/im/flags/out_valid stable, in_ready = 0, add_a = add_b = 0. Raising out_ready with in_valid = 0 -> IDLE next cycle, busy = 0.
- Back-to-back: out_ready = 1, in_valid held high with 4 distinct operand sets -> 4 results at 3-cycle spacing, in order, each matching ac - bd and ad + bc.
- Abort: assert rst while in IMAG -> out_valid is never raised for that set. The next accepted set produces correct results with no stale flags.

Source files
------------

// File: rtl/cmplx_add_sched_if.sv
// Purpose : bundles the operand handshake, the shared-adder port and the
//           result handshake of cmplx_add_sched into one interface.
// Signals : in_valid/in_ready + ac/bd/ad/bc   operand set from the multiplier array
//           add_a/add_b/add_cin -> add_sum     external W-bit adder (combinational)
//           out_valid/out_ready + re/im/flags  result towards the output registers
//           busy                               scheduler is not idle
// Modports: slave  - the scheduler itself
//           master - the surroundings (producer, adder, consumer)
interface cmplx_add_sched_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ac;
    logic [W-1:0] bd;
    logic [W-1:0] ad;
    logic [W-1:0] bc;

    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_sum;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         re_ovf;
    logic         im_ovf;
    logic         busy;

    modport slave (
        input  in_valid, ac, bd, ad, bc, add_sum, out_ready,
        output in_ready, add_a, add_b, add_cin,
        output out_valid, re, im, re_ovf, im_ovf, busy
    );

    modport master (
        output in_valid, ac, bd, ad, bc, add_sum, out_ready,
        input  in_ready, add_a, add_b, add_cin,
        input  out_valid, re, im, re_ovf, im_ovf, busy
    );
endinterface

// File: rtl/cmplx_add_sched.sv
// Purpose : time-shares one external W-bit adder to finish a complex product:
//           re = ac - bd (pass 1), im = ad + bc (pass 2). Results and signed
//           overflow flags are held until the consumer takes them.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous, active-high reset (aborts any pass)
//           bus  - cmplx_add_sched_if.slave (operands, adder, results, busy)
module cmplx_add_sched #(
    parameter int W = 64
) (
    input  logic                clk,
    input  logic                rst,
    cmplx_add_sched_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REAL = 2'd1,
        IMAG = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] ac_q, ac_d;
    logic [W-1:0] bd_q, bd_d;
    logic [W-1:0] ad_q, ad_d;
    logic [W-1:0] bc_q, bc_d;
    logic [W-1:0] re_q, re_d;
    logic [W-1:0] im_q, im_d;
    logic         re_ovf_q, re_ovf_d;
    logic         im_ovf_q, im_ovf_d;

    logic         in_ready;
    logic         accept;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no branch
        // can leave one unassigned and turn it into a latch.
        state_d  = state_q;
        ac_d     = ac_q;
        bd_d     = bd_q;
        ad_d     = ad_q;
        bc_d     = bc_q;
        re_d     = re_q;
        im_d     = im_q;
        re_ovf_d = re_ovf_q;
        im_ovf_d = im_ovf_q;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;

        // A consumer taking the result in DONE frees the slot in the same
        // cycle, which is what gives one result every three cycles.
        in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
        accept   = bus.in_valid & in_ready;

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = REAL;
            end
            REAL: begin
                // ac - bd as ac + ~bd + 1 on the shared adder.
                add_a    = ac_q;
                add_b    = ~bd_q;
                add_cin  = 1'b1;
                re_d     = bus.add_sum;
                re_ovf_d = (ac_q[W-1] != bd_q[W-1]) & (bus.add_sum[W-1] != ac_q[W-1]);
                state_d  = IMAG;
            end
            IMAG: begin
                add_a    = ad_q;
                add_b    = bc_q;
                im_d     = bus.add_sum;
                im_ovf_d = (ad_q[W-1] == bc_q[W-1]) & (bus.add_sum[W-1] != ad_q[W-1]);
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = accept ? REAL : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            ac_d = bus.ac;
            bd_d = bus.bd;
            ad_d = bus.ad;
            bc_d = bus.bc;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ac_q     <= '0;
            bd_q     <= '0;
            ad_q     <= '0;
            bc_q     <= '0;
            re_q     <= '0;
            im_q     <= '0;
            re_ovf_q <= 1'b0;
            im_ovf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ac_q     <= ac_d;
            bd_q     <= bd_d;
            ad_q     <= ad_d;
            bc_q     <= bc_d;
            re_q     <= re_d;
            im_q     <= im_d;
            re_ovf_q <= re_ovf_d;
            im_ovf_q <= im_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.add_a     = add_a;
    assign bus.add_b     = add_b;
    assign bus.add_cin   = add_cin;
    assign bus.out_valid = (state_q == DONE);
    assign bus.re        = re_q;
    assign bus.im        = im_q;
    assign bus.re_ovf    = re_ovf_q;
    assign bus.im_ovf    = im_ovf_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cmplx_add_sched.sv
// Purpose : self-checking bench for cmplx_add_sched (W=64). Provides the
//           external adder, directed cases and random streams scored against
//           an exact-width arithmetic reference.
module tb_cmplx_add_sched;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         re_ovf;
        logic         im_ovf;
    } res_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_bad;

    cmplx_add_sched_if #(.W(W)) bus ();

    cmplx_add_sched #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // The external combinational adder.
    assign bus.add_sum = bus.add_a + bus.add_b + {{(W-1){1'b0}}, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: sign-extend to W+1 bits and do the arithmetic exactly; the
    // result overflowed when the two top bits disagree.
    function automatic res_t model(input logic [W-1:0] ac, bd, ad, bc);
        res_t           m;
        logic [W:0]     r;
        logic [W:0]     i;
        r = $signed({ac[W-1], ac}) - $signed({bd[W-1], bd});
        i = $signed({ad[W-1], ad}) + $signed({bc[W-1], bc});
        m.re     = r[W-1:0];
        m.im     = i[W-1:0];
        m.re_ovf = (r[W] != r[W-1]);
        m.im_ovf = (i[W] != i[W-1]);
        return m;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        case ($urandom_range(7))
            0:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = '1;
            3:       v = '0;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operand set and waits (bounded) for the accepting edge.
    // Returns just after that edge, with in_valid dropped.
    task automatic accept_set(input logic [W-1:0] a, b, c, d);
        bit done;
        done = 1'b0;
        bus.ac = a; bus.bd = b; bus.ad = c; bus.bc = d;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                tick();
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    // One full operation with out_ready high; checks both adder passes and
    // the result presented in DONE.
    task automatic run_check(input string tag, input logic [W-1:0] a, b, c, d);
        res_t e;
        e = model(a, b, c, d);
        bus.out_ready = 1'b1;
        accept_set(a, b, c, d);
        @(negedge clk);
        check({tag, "_real_cin"}, bus.add_cin, 1);
        check({tag, "_real_a"}, bus.add_a, a);
        check({tag, "_real_b"}, bus.add_b, ~b);
        check({tag, "_real_valid"}, bus.out_valid, 0);
        @(negedge clk);
        check({tag, "_imag_cin"}, bus.add_cin, 0);
        check({tag, "_imag_a"}, bus.add_a, c);
        check({tag, "_imag_b"}, bus.add_b, d);
        check({tag, "_imag_ready"}, bus.in_ready, 0);
        @(negedge clk);
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_re"}, bus.re, e.re);
        check({tag, "_im"}, bus.im, e.im);
        check({tag, "_re_ovf"}, bus.re_ovf, e.re_ovf);
        check({tag, "_im_ovf"}, bus.im_ovf, e.im_ovf);
        tick();
    endtask

    // Random stream scored through a queue. With gap_chk set, consecutive
    // results must be exactly three cycles apart.
    task automatic stream(input string tag, input int n, input int p_valid,
                          input int p_ready, input bit gap_chk);
        res_t q[$];
        res_t e;
        int   acc;
        int   got;
        int   cyc;
        int   last;
        acc = 0; got = 0; cyc = 0; last = -1;
        while (got < n && cyc < 100 * n) begin
            bus.in_valid  = (acc < n) && ($urandom_range(99) < p_valid);
            bus.out_ready = ($urandom_range(99) < p_ready);
            bus.ac = rand_op(); bus.bd = rand_op();
            bus.ad = rand_op(); bus.bc = rand_op();
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.ac, bus.bd, bus.ad, bus.bc));
                acc++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check({tag, "_spurious"}, 1, 0);
                end else begin
                    e = q.pop_front();
                    check({tag, "_re"}, bus.re, e.re);
                    check({tag, "_im"}, bus.im, e.im);
                    check({tag, "_re_ovf"}, bus.re_ovf, e.re_ovf);
                    check({tag, "_im_ovf"}, bus.im_ovf, e.im_ovf);
                end
                if (gap_chk && last >= 0) check({tag, "_gap"}, cyc - last, 3);
                last = cyc;
                got++;
            end
            tick();
            cyc++;
        end
        check({tag, "_count"}, got, n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        res_t e;
        int   stray;
        n_checks = 0;
        n_bad    = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.ac = '0; bus.bd = '0; bus.ad = '0; bus.bc = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset asserted mid-cycle while operands are offered.
        bus.in_valid = 1'b1;
        bus.ac = 64'd5; bus.bd = 64'd1; bus.ad = 64'd2; bus.bc = 64'd3;
        #2;
        rst = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_re", bus.re, 0);
        check("rst_im", bus.im, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_re_ovf", bus.re_ovf, 0);
        check("post_rst_im_ovf", bus.im_ovf, 0);
        tick();

        run_check("basic", 64'd10, 64'd3, 64'd4, 64'd5);
        run_check("neg", 64'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        run_check("re_ovf", 64'h8000_0000_0000_0000, 64'd1, 64'd0, 64'd0);

        // Backpressure: five cycles held in DONE.
        bus.out_ready = 1'b0;
        e = model(64'hFFFF_FFFF_FFFF_FFF0, 64'd7, 64'h8000_0000_0000_0000, '1);
        accept_set(64'hFFFF_FFFF_FFFF_FFF0, 64'd7, 64'h8000_0000_0000_0000, '1);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_add_a", bus.add_a, 0);
            check("bp_add_b", bus.add_b, 0);
            check("bp_re", bus.re, e.re);
            check("bp_im", bus.im, e.im);
            check("bp_flags", {bus.re_ovf, bus.im_ovf}, {e.re_ovf, e.im_ovf});
        end
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("bp_idle_busy", bus.busy, 0);
        check("bp_idle_valid", bus.out_valid, 0);
        tick();

        // Abort in IMAG: the partial result must never be presented.
        accept_set(64'h8000_0000_0000_0000, 64'd1, 64'd11, 64'd22);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.out_valid, 0);
        check("abort_re", bus.re, 0);
        check("abort_re_ovf", bus.re_ovf, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        check("abort_no_valid", stray, 0);
        tick();
        run_check("after_abort", 64'd100, 64'd40, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);

        stream("b2b4", 4, 100, 100, 1'b1);
        stream("rand", 40, 70, 60, 1'b0);
        stream("b2b", 20, 100, 100, 1'b1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
